// File: rtl/lcd_bus_reader.sv
// Read-side controller for an HD44780-style LCD bus: fetches busy flag/address (RS=0) or data (RS=1).
// Optional busy-flag polling is enabled with `define LCD_BUSY_POLL_EN (adds POLL_MAX, oTimeout, GAP state).
module lcd_bus_reader #(
   parameter int unsigned T_SETUP  = 4,
   parameter int unsigned T_EN     = 25,
   parameter int unsigned T_HOLD   = 4,
   parameter int unsigned CNT_W    = 16
`ifdef LCD_BUSY_POLL_EN
   ,
   parameter int unsigned POLL_MAX = 255
`endif
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iStart,
   input  logic       iRS,
   output logic       oReady,
   output logic       oDone,
   output logic [7:0] oDATA,
   output logic       oBusy,
   output logic [6:0] oAddr,
   input  logic [7:0] LCD_DATA_IN,
   output logic       LCD_DATA_OE,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic       LCD_RS
`ifdef LCD_BUSY_POLL_EN
   ,
   output logic       oTimeout
`endif
);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_EN_HI,
      S_HOLD,
      S_DONE
`ifdef LCD_BUSY_POLL_EN
      ,
      S_GAP
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic [7:0]       data_q, data_d;
   logic             busy_q, busy_d;
   logic [6:0]       addr_q, addr_d;
   logic             en_q, en_d;
   logic             rw_q, rw_d;
   logic             rs_q, rs_d;
   logic             oe_q, oe_d;
`ifdef LCD_BUSY_POLL_EN
   localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);
   logic [15:0]      poll_q, poll_d;
   logic             timeout_q, timeout_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      data_d  = data_q;
      busy_d  = busy_q;
      addr_d  = addr_q;
      en_d    = en_q;
      rw_d    = rw_q;
      rs_d    = rs_q;
      oe_d    = oe_q;
`ifdef LCD_BUSY_POLL_EN
      poll_d    = poll_q;
      timeout_d = timeout_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (iStart) begin
               rs_d    = iRS;
               rw_d    = 1'b1;
               oe_d    = 1'b0;
               ready_d = 1'b0;
               cnt_d   = '0;
               state_d = S_SETUP;
`ifdef LCD_BUSY_POLL_EN
               poll_d    = '0;
               timeout_d = 1'b0;
`endif
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               en_d    = 1'b1;
               cnt_d   = '0;
               state_d = S_EN_HI;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_EN_HI: begin
            // Sample on the final EN-high cycle so the panel's data-delay margin is fully used.
            if (cnt_q == EN_LAST) begin
               data_d = LCD_DATA_IN;
               if (!rs_q) begin
                  busy_d = LCD_DATA_IN[7];
                  addr_d = LCD_DATA_IN[6:0];
               end
               en_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_HOLD;
`ifdef LCD_BUSY_POLL_EN
               poll_d = poll_q + 16'd1;
`endif
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               rw_d  = 1'b0;
               oe_d  = 1'b1;
               cnt_d = '0;
`ifdef LCD_BUSY_POLL_EN
               if (!rs_q && busy_q && (poll_q < POLL_LIM)) begin
                  state_d = S_GAP;
               end else begin
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  timeout_d = !rs_q && busy_q;
               end
`else
               state_d = S_DONE;
               done_d  = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
`ifdef LCD_BUSY_POLL_EN
         S_GAP: begin
            if (cnt_q == HOLD_LAST) begin
               rw_d    = 1'b1;
               oe_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_SETUP;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
`endif
         S_DONE: begin
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         addr_q  <= '0;
         en_q    <= 1'b0;
         rw_q    <= 1'b0;
         rs_q    <= 1'b0;
         oe_q    <= 1'b1;
`ifdef LCD_BUSY_POLL_EN
         poll_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         addr_q  <= addr_d;
         en_q    <= en_d;
         rw_q    <= rw_d;
         rs_q    <= rs_d;
         oe_q    <= oe_d;
`ifdef LCD_BUSY_POLL_EN
         poll_q    <= poll_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign oReady      = ready_q;
   assign oDone       = done_q;
   assign oDATA       = data_q;
   assign oBusy       = busy_q;
   assign oAddr       = addr_q;
   assign LCD_EN      = en_q;
   assign LCD_RW      = rw_q;
   assign LCD_RS      = rs_q;
   assign LCD_DATA_OE = oe_q;
`ifdef LCD_BUSY_POLL_EN
   assign oTimeout    = timeout_q;
`endif

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Randomised self-checking bench for lcd_bus_reader against a phase-offset reference model.
module tb_lcd_bus_reader;

   localparam int TS  = 4;
   localparam int TE  = 25;
   localparam int TH  = 4;
   localparam int TOT = TS + TE + TH;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       rs_in = 1'b0;
   logic [7:0] din = 8'h00;
   logic       oReady, oDone, oBusy, LCD_DATA_OE, LCD_RW, LCD_EN, LCD_RS;
   logic [7:0] oDATA;
   logic [6:0] oAddr;
`ifdef LCD_BUSY_POLL_EN
   logic       oTimeout;
`endif

   lcd_bus_reader #(.T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .CNT_W(16)) dut (
      .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iRS(rs_in),
      .oReady(oReady), .oDone(oDone), .oDATA(oDATA), .oBusy(oBusy), .oAddr(oAddr),
      .LCD_DATA_IN(din), .LCD_DATA_OE(LCD_DATA_OE), .LCD_RW(LCD_RW),
      .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
`ifdef LCD_BUSY_POLL_EN
      , .oTimeout(oTimeout)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   bit check_en = 1'b0;

   // Model: p = edges since the accepting edge while a read is in flight, -1 when idle.
   int         p = -1;
   logic       m_rs = 1'b0;
   logic [7:0] m_data = 8'h00;
   logic       m_busy = 1'b0;
   logic [6:0] m_addr = 7'h00;
   int         cyc = 0;
   int         acc_cyc = 0;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         p = -1; m_rs = 1'b0; m_data = 8'h00; m_busy = 1'b0; m_addr = 7'h00;
      end else if (p < 0) begin
         if (start) begin
            p = 0; m_rs = rs_in; acc_cyc = cyc;
         end
      end else if (p == TOT) begin
         p = -1;
      end else begin
         p++;
         if (p == TS + TE) begin
            m_data = din;
            if (!m_rs) begin
               m_busy = din[7];
               m_addr = din[6:0];
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
      end
   endtask

   int en_cnt = 0;
   int rw_cnt = 0;
   int done_cyc = -1;

   always @(negedge clk) begin
      if (check_en) begin
         automatic bit busy_rw = (p >= 0) && (p < TOT);
         chk("oReady", {7'd0, oReady}, {7'd0, p < 0});
         chk("oDone", {7'd0, oDone}, {7'd0, p == TOT});
         chk("LCD_RW", {7'd0, LCD_RW}, {7'd0, busy_rw});
         chk("LCD_DATA_OE", {7'd0, LCD_DATA_OE}, {7'd0, !busy_rw});
         chk("LCD_EN", {7'd0, LCD_EN}, {7'd0, (p >= TS) && (p < TS + TE)});
         chk("LCD_RS", {7'd0, LCD_RS}, {7'd0, m_rs});
         chk("oDATA", oDATA, m_data);
         chk("oBusy", {7'd0, oBusy}, {7'd0, m_busy});
         chk("oAddr", {1'b0, oAddr}, {1'b0, m_addr});
      end
      if (LCD_EN === 1'b1) en_cnt++;
      if (LCD_RW === 1'b1) rw_cnt++;
      if (oDone === 1'b1) done_cyc = cyc;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_p(input int target, input int budget);
      for (int i = 0; i < budget && p != target; i++) tick();
      chk("wait_phase", (p == target) ? 8'd1 : 8'd0, 8'd1);
   endtask

   task automatic issue(input logic rs, input logic [7:0] d);
      din = d; rs_in = rs; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rs_in = 1'b0;
      din = 8'h00;
      start = 1'b0;
      rst_n = 1'b0;
      tick();
      check_en = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_ready", {7'd0, oReady}, 8'd1);
      chk("rst_oe", {7'd0, LCD_DATA_OE}, 8'd1);
      chk("rst_data", oDATA, 8'h00);

      // Single RS=0 read
      en_cnt = 0; rw_cnt = 0; done_cyc = -1;
      issue(1'b0, 8'h85);
      wait_p(TOT, 60);
      chk("t1_done", {7'd0, oDone}, 8'd1);
      chk("t1_data", oDATA, 8'h85);
      chk("t1_busy", {7'd0, oBusy}, 8'd1);
      chk("t1_addr", {1'b0, oAddr}, 8'h05);
      wait_p(-1, 5);
      chk("t1_en_cycles", 8'(en_cnt), 8'd25);
      chk("t1_rw_cycles", 8'(rw_cnt), 8'd33);
      chk("t1_done_latency", 8'(done_cyc - acc_cyc + 1), 8'd34);

      // Single RS=1 read keeps BF/address
      issue(1'b1, 8'h4A);
      wait_p(TOT, 60);
      chk("t2_data", oDATA, 8'h4A);
      chk("t2_busy", {7'd0, oBusy}, 8'd1);
      chk("t2_addr", {1'b0, oAddr}, 8'h05);
      wait_p(-1, 5);

      // Mid-cycle request toggling and late data change
      issue(1'b0, 8'h11);
      wait_p(TS + 2, 20);
      start = 1'b1; rs_in = 1'b1; tick();
      start = 1'b0; rs_in = 1'b0; tick();
      start = 1'b1; rs_in = 1'b1; tick();
      start = 1'b0;
      wait_p(TS + TE - 2, 40);
      din = 8'h22;
      wait_p(TOT, 20);
      chk("t3_data", oDATA, 8'h22);
      chk("t3_addr", {1'b0, oAddr}, 8'h22);
      chk("t3_busy", {7'd0, oBusy}, 8'd0);
      wait_p(-1, 5);

      // Reset during EN high aborts the read
      issue(1'b0, 8'hC3);
      wait_p(10, 20);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t4_en", {7'd0, LCD_EN}, 8'd0);
      chk("t4_rw", {7'd0, LCD_RW}, 8'd0);
      chk("t4_oe", {7'd0, LCD_DATA_OE}, 8'd1);
      done_cyc = -1;
      for (int i = 0; i < 40; i++) tick();
      chk("t4_no_done", (done_cyc == -1) ? 8'd1 : 8'd0, 8'd1);

      // Back-to-back: start held across a completion
      start = 1'b1; rs_in = 1'b0; din = 8'h07;
      wait_p(TOT, 60);
      wait_p(-1, 3);
      wait_p(0, 3);
      start = 1'b0;
      wait_p(-1, 60);

      // Randomised traffic with occasional resets
      for (int i = 0; i < 2500; i++) begin
         start = ($urandom_range(0, 3) != 0);
         rs_in = 1'($urandom_range(0, 1));
         din   = 8'($urandom_range(0, 255));
         rst_n = ($urandom_range(0, 399) != 0);
         tick();
      end
      rst_n = 1'b1;
      start = 1'b0;
      wait_p(-1, 60);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
